quad_decoder: RTL
=================

// Module: quad_decoder
// PURPOSE
//  Quadrature (A/B) decoder and position counter.
//  - Receiving end of a 2-bit Gray-coded step interface: the same up/down/load semantics as the team's
//    up/down counter, but the direction is decoded from the phase order of two asynchronous inputs.
//  - Sits between an external encoder/stimulus and downstream position logic.
// PARAMETERS
//  WIDTH     8  position counter width (bits); wraps modulo 2**WIDTH
//  FILT_CYC  3  cycles a synchronised {a,b} must be stable before use (only with QDEC_FILTER_EN); >=1
// PORTS
//  clk       in   1      single clock, all flops on posedge
//  rst       in   1      synchronous, active-high reset
//  a_in      in   1      encoder phase A, asynchronous to clk
//  b_in      in   1      encoder phase B, asynchronous to clk
//  load      in   1      load pos from load_val this cycle
//  load_val  in   WIDTH  value for load
//  clr_err   in   1      clear err (sticky flag)
//  pos       out  WIDTH  position count
//  dir       out  1      direction of last valid step: 1=up, 0=down
//  step      out  1      1-cycle pulse on each counted step
//  err       out  1      sticky: illegal transition seen (both phases changed)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): pos=0, dir=0, step=0, err=0; sync flops, prev state and FSM cleared.
//    rst asserted mid-operation aborts everything on that edge.
//  - Sync: 2-flop synchroniser per input; the synchronised pair is cur={a_s,b_s}.
//  - FSM:
//      S_FILL : 2 cycles after reset, sync pipe fills; no counting.
//      S_ARM  : prev<=cur without counting (no false step or err from reset state); -> S_RUN.
//      S_RUN  : every cycle compare prev vs cur, then prev<=cur.
//  - Decode {a,b}:
//      up   = 00->10->11->01->00 (A leads)
//      down = 00->01->11->10->00 (B leads)
//      no change -> nothing
//      both bits changed (00<->11, 10<->01) -> err<=1; pos, dir unchanged; step=0
//  - Valid step: pos<=pos+/-1 (mod 2**WIDTH: max+1->0, 0-1->max); dir updated; step=1 for exactly 1 cycle.
//  - Latency: input edge stable before posedge k -> pos/step update at posedge k+2 (sync x2 + compare).
//  - load=1 (any state after reset): pos<=load_val. Priority over a same-cycle step.
//    prev still tracks cur; dir unchanged; step=0.
//  - clr_err=1: err<=0 unless an illegal transition occurs in the same cycle (set wins).
//  - Priority: rst > load > step decode. clr_err is independent of load.
// CONFIGURATION
//  QDEC_FILTER_EN defined:
//    - Stability filter after the synchroniser. cur only takes a new {a_s,b_s} value after that value
//      has been constant for FILT_CYC consecutive cycles.
//    - Latency grows by FILT_CYC cycles. Shorter pulses are rejected.
//    - Filter counter resets to 0.
//  QDEC_FILTER_EN undefined: no filter; cur = synchroniser output; FILT_CYC ignored.
// STRUCTURE
//  - Package quad_pkg:
//      state enum (S_FILL, S_ARM, S_RUN)
//      localparams for phase codes PH_00/PH_10/PH_11/PH_01
//      function qstep(prev,cur) -> {valid,up,illegal}
//  - Sub-module quad_sync_filt: synchroniser + optional filter; output cur[1:0].
//  - Top: FSM, decode, counter, flags.
// TESTING
//  1 Reset with a_in=b_in=1, release, hold 10 cycles -> pos=0, step never 1, err=0.
//  2 WIDTH=8, 4 up steps (00,10,11,01,00), each held 6 cycles
//      -> pos=4, dir=1, 4 step pulses, each 2 cycles after its input edge.
//  3 load=1, load_val=8'h00, then 1 down step -> pos=8'hFF, dir=0; from 8'hFF 1 up step -> 8'h00.
//  4 Jump 00->11 -> err=1, pos unchanged. err holds until clr_err=1 for 1 cycle -> err=0.
//  5 load=1, load_val=8'h55 on the same cycle a step is decoded -> pos=8'h55, step=0.
//    The next step counts from 8'h55.
//  6 QDEC_FILTER_EN, FILT_CYC=3:
//      2-cycle glitch on a_in -> no step
//      clean edge -> step 2+3 cycles after the edge.
//    Also: rst mid-sequence -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and decode helper for the quadrature decoder.
// Phase codes are {a,b}. Forward (up) order is 00 -> 10 -> 11 -> 01 -> 00.
package quad_pkg;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_10 = 2'b10;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_01 = 2'b01;

   typedef struct packed {
      logic valid;
      logic up;
      logic illegal;
   } qstep_t;

   // Classify one transition between consecutive phase codes
   function automatic qstep_t qstep(input logic [1:0] prev, input logic [1:0] cur);
      qstep_t     r;
      logic [1:0] nxt_up;
      r = '0;
      case (prev)
         PH_00:   nxt_up = PH_10;
         PH_10:   nxt_up = PH_11;
         PH_11:   nxt_up = PH_01;
         default: nxt_up = PH_00;
      endcase
      if ((prev ^ cur) == 2'b11) begin
         r.illegal = 1'b1;
      end else if (prev != cur) begin
         r.valid = 1'b1;
         r.up    = (cur == nxt_up);
      end
      return r;
   endfunction

endpackage

// File: rtl/quad_sync_filt.sv
// Two-flop synchroniser for the A/B phases, plus an optional stability filter
// enabled by defining QDEC_FILTER_EN (a new code is accepted after FILT_CYC stable cycles).
module quad_sync_filt #(
   parameter int FILT_CYC = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_in,
   input  logic       b_in,
   output logic [1:0] cur
);

   if (FILT_CYC < 1) begin : g_bad_filt
      $error("FILT_CYC must be at least 1");
   end

   logic [1:0] sync1_q;
   logic [1:0] sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {a_in, b_in};
         sync2_q <= sync1_q;
      end
   end

`ifdef QDEC_FILTER_EN
   localparam int CW = $clog2(FILT_CYC + 1);
   localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYC);

   logic [1:0]    cand_q;
   logic [1:0]    cur_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Run length of the current differing value, restarting whenever it changes
   always_comb begin
      cnt_d = (sync2_q == cand_q) ? cnt_q + 1'b1 : {{(CW-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_q <= 2'b00;
         cur_q  <= 2'b00;
         cnt_q  <= '0;
      end else begin
         cand_q <= sync2_q;
         if (sync2_q == cur_q) begin
            cnt_q <= '0;
         end else if (cnt_d >= FILT_MAX) begin
            cur_q <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   assign cur = cur_q;
`else
   assign cur = sync2_q;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder with wrapping position counter, load, and sticky error flag.
// QDEC_FILTER_EN adds an input stability filter in quad_sync_filt.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int FILT_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_err,
   output logic [WIDTH-1:0] pos,
   output logic             dir,
   output logic             step,
   output logic             err
);

   // Arming waits until cur reflects the real inputs, including filter delay
`ifdef QDEC_FILTER_EN
   localparam int FILL_CYC = 2 + FILT_CYC;
`else
   localparam int FILL_CYC = 2;
`endif
   localparam int FW = $clog2(FILL_CYC + 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYC - 1);

   logic [1:0]       cur_w;
   logic [1:0]       prev_q;
   state_t           state_q, state_d;
   logic [FW-1:0]    fill_cnt_q;
   logic             run_en;
   qstep_t           qs;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;

   quad_sync_filt #(.FILT_CYC(FILT_CYC)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .a_in (a_in),
      .b_in (b_in),
      .cur  (cur_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FILL;
         fill_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_FILL) fill_cnt_q <= fill_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (fill_cnt_q == FILL_LAST) state_d = S_ARM;
         S_ARM:   state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      run_en = (state_q == S_RUN);
   end

   assign qs = qstep(prev_q, cur_w);

   always_comb begin
      pos_d  = pos_q;
      dir_d  = dir_q;
      step_d = 1'b0;
      err_d  = clr_err ? 1'b0 : err_q;
      if (run_en) begin
         if (qs.illegal) begin
            err_d = 1'b1;
         end else if (qs.valid && !load) begin
            pos_d  = qs.up ? pos_q + 1'b1 : pos_q - 1'b1;
            dir_d  = qs.up;
            step_d = 1'b1;
         end
      end
      if (load) pos_d = load_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 2'b00;
         pos_q  <= '0;
         dir_q  <= 1'b0;
         step_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= cur_w;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         step_q <= step_d;
         err_q  <= err_d;
      end
   end

   assign pos  = pos_q;
   assign dir  = dir_q;
   assign step = step_q;
   assign err  = err_q;

endmodule
